lsu_mem_if: RTL and testbench

Load/store unit between the register file and the data-memory bus.
- Takes base (rs1 data), store data (rs2 data), immediate and funct3 for one load or store.
- Runs a req/ready handshake with data memory, with aligned byte lanes and strobes.
- Returns sign- or zero-extended load data, plus rd address, to the register-file write port.
- Stalls the core via req_ready while an access is in flight; flags misaligned, illegal and timed-out accesses.

---
 rtl/lsu_mem_if.sv | 164 ++++++++++++++++
 tb/tb_lsu_mem_if.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_if.sv
// Load/store unit bridging register-file operands to a single-beat data-memory bus.
// Faults (illegal funct3, misaligned, timeout) are reported without touching memory where possible.
module lsu_mem_if #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_is_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_rs1_data,
    input  logic [31:0] req_rs2_data,
    input  logic [31:0] req_imm,
    input  logic [4:0]  req_rd_addr,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        wb_valid,
    output logic [4:0]  wb_rd_addr,
    output logic [31:0] wb_data,
    output logic        done,
    output logic        fault,
    output logic [1:0]  fault_code
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP, FAULT} state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, wdata_q, wb_data_q;
    logic [3:0]  wstrb_q;
    logic [1:0]  off_q, fcode_q;
    logic [2:0]  funct3_q;
    logic        is_store_q;
    logic [4:0]  rd_q;
    logic [15:0] cnt_q;

    logic [31:0] ea, wdata_acc, load_ext;
    logic [3:0]  wstrb_acc;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic        accept, illegal, misaligned, timeout_hit;

    assign ea          = req_rs1_data + req_imm;
    assign accept      = req_valid && (state_q == IDLE);
    assign timeout_hit = (state_q == ACCESS) && !mem_ready
                         && (cnt_q == 16'(TIMEOUT_CYCLES - 1));

    always_comb begin
        illegal    = 1'b0;
        misaligned = 1'b0;
        if (req_is_store)
            illegal = !(req_funct3 inside {3'b000, 3'b001, 3'b010});
        else
            illegal = !(req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        if (req_funct3[1:0] == 2'b01)
            misaligned = ea[0];
        else if (req_funct3[1:0] == 2'b10)
            misaligned = (ea[1:0] != 2'b00);
    end

    // Store data is replicated across lanes so memory only needs the strobes.
    always_comb begin
        wdata_acc = 32'd0;
        wstrb_acc = 4'b0000;
        if (req_is_store) begin
            case (req_funct3[1:0])
                2'b00: begin
                    wdata_acc = {4{req_rs2_data[7:0]}};
                    wstrb_acc = 4'b0001 << ea[1:0];
                end
                2'b01: begin
                    wdata_acc = {2{req_rs2_data[15:0]}};
                    wstrb_acc = 4'b0011 << {ea[1], 1'b0};
                end
                default: begin
                    wdata_acc = req_rs2_data;
                    wstrb_acc = 4'b1111;
                end
            endcase
        end
    end

    always_comb begin
        ld_byte  = 8'(mem_rdata >> {off_q, 3'b000});
        ld_half  = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        load_ext = mem_rdata;
        case (funct3_q)
            3'b000:  load_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  load_ext = {{16{ld_half[15]}}, ld_half};
            3'b100:  load_ext = {24'd0, ld_byte};
            3'b101:  load_ext = {16'd0, ld_half};
            default: load_ext = mem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = (illegal || misaligned) ? FAULT : ACCESS;
            ACCESS:  if (mem_ready) state_d = RESP;
                     else if (timeout_hit) state_d = FAULT;
            RESP:    state_d = IDLE;
            FAULT:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = (state_q == IDLE);
        mem_req    = (state_q == ACCESS);
        mem_we     = (state_q == ACCESS) && is_store_q;
        done       = (state_q == RESP);
        wb_valid   = (state_q == RESP) && !is_store_q;
        fault      = (state_q == FAULT);
        fault_code = (state_q == FAULT) ? fcode_q : 2'b00;
        mem_addr   = addr_q;
        mem_wdata  = wdata_q;
        mem_wstrb  = wstrb_q;
        wb_data    = wb_data_q;
        wb_rd_addr = rd_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            wstrb_q    <= 4'd0;
            off_q      <= 2'd0;
            funct3_q   <= 3'd0;
            is_store_q <= 1'b0;
            rd_q       <= 5'd0;
            fcode_q    <= 2'd0;
            wb_data_q  <= 32'd0;
            cnt_q      <= 16'd0;
        end else begin
            if (accept) begin
                addr_q     <= {ea[31:2], 2'b00};
                off_q      <= ea[1:0];
                funct3_q   <= req_funct3;
                is_store_q <= req_is_store;
                rd_q       <= req_rd_addr;
                wdata_q    <= wdata_acc;
                wstrb_q    <= wstrb_acc;
                fcode_q    <= illegal ? 2'b10 : 2'b01;
            end
            if ((state_q == ACCESS) && mem_ready)
                wb_data_q <= load_ext;
            if (timeout_hit)
                fcode_q <= 2'b11;
            cnt_q <= ((state_q == ACCESS) && !mem_ready) ? cnt_q + 16'd1 : 16'd0;
        end
    end

endmodule

// File: tb/tb_lsu_mem_if.sv
// Directed bench for lsu_mem_if: hand-computed vectors for loads, stores, faults,
// timeout and reset-abort, checked with immediate assertions at each step.
module tb_lsu_mem_if;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_is_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_rs1_data, req_rs2_data, req_imm;
    logic [4:0]  req_rd_addr;
    logic        mem_req, mem_we, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;
    logic        wb_valid, done, fault;
    logic [4:0]  wb_rd_addr;
    logic [31:0] wb_data;
    logic [1:0]  fault_code;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lsu_mem_if #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
        .req_funct3(req_funct3), .req_rs1_data(req_rs1_data), .req_rs2_data(req_rs2_data),
        .req_imm(req_imm), .req_rd_addr(req_rd_addr),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .wb_valid(wb_valid), .wb_rd_addr(wb_rd_addr), .wb_data(wb_data),
        .done(done), .fault(fault), .fault_code(fault_code)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Present one request at the current negedge; returns at the next negedge (cycle 1).
    task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] rs1,
                         input logic [31:0] rs2, input logic [31:0] imm, input logic [4:0] rd);
        chk("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid    = 1'b1;
        req_is_store = st;
        req_funct3   = f3;
        req_rs1_data = rs1;
        req_rs2_data = rs2;
        req_imm      = imm;
        req_rd_addr  = rd;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic chk_access(input string tag, input logic [31:0] addr, input logic we,
                              input logic [31:0] wdata, input logic [3:0] wstrb);
        chk({tag, "_mem_req"}, 32'(mem_req), 32'd1);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
        chk({tag, "_mem_addr"}, mem_addr, addr);
        chk({tag, "_mem_we"}, 32'(mem_we), 32'(we));
        chk({tag, "_mem_wstrb"}, 32'(mem_wstrb), 32'(wstrb));
        if (we) chk({tag, "_mem_wdata"}, mem_wdata, wdata);
    endtask

    // Complete an access: mem_ready now, then check the RESP cycle and the return to IDLE.
    task automatic respond(input string tag, input logic [31:0] rdata, input logic is_load,
                           input logic [31:0] exp_data, input logic [4:0] exp_rd);
        mem_ready = 1'b1;
        mem_rdata = rdata;
        @(negedge clk);
        mem_ready = 1'b0;
        mem_rdata = 32'hDEAD_0000;
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_wb_valid"}, 32'(wb_valid), 32'(is_load));
        chk({tag, "_mem_req_drop"}, 32'(mem_req), 32'd0);
        chk({tag, "_fault"}, 32'(fault), 32'd0);
        if (is_load) begin
            chk({tag, "_wb_data"}, wb_data, exp_data);
            chk({tag, "_wb_rd"}, 32'(wb_rd_addr), 32'(exp_rd));
        end
        @(negedge clk);
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
        chk({tag, "_wb_valid_pulse"}, 32'(wb_valid), 32'd0);
    endtask

    task automatic expect_fault(input string tag, input logic [1:0] code);
        chk({tag, "_fault"}, 32'(fault), 32'd1);
        chk({tag, "_code"}, 32'(fault_code), 32'(code));
        chk({tag, "_mem_req"}, 32'(mem_req), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_wb_valid"}, 32'(wb_valid), 32'd0);
        @(negedge clk);
        chk({tag, "_fault_pulse"}, 32'(fault), 32'd0);
        chk({tag, "_ready_back"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 1'b0; req_is_store = 1'b0; req_funct3 = 3'd0;
        req_rs1_data = 32'd0; req_rs2_data = 32'd0; req_imm = 32'd0; req_rd_addr = 5'd0;
        mem_ready = 1'b0; mem_rdata = 32'd0;
        repeat (2) @(negedge clk);

        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_fault_code", 32'(fault_code), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // LB at ea 0x1003; a stray mem_ready while IDLE must be ignored.
        mem_ready = 1'b1;
        issue(1'b0, 3'b000, 32'h0000_1000, 32'd0, 32'd3, 5'd5);
        mem_ready = 1'b0;
        chk_access("lb", 32'h0000_1000, 1'b0, 32'd0, 4'b0000);
        respond("lb", 32'h80FF_0000, 1'b1, 32'hFFFF_FF80, 5'd5);

        issue(1'b1, 3'b001, 32'h0000_2000, 32'hDEAD_BEEF, 32'd2, 5'd0);
        chk_access("sh", 32'h0000_2000, 1'b1, 32'hBEEF_BEEF, 4'b1100);
        respond("sh", 32'd0, 1'b0, 32'd0, 5'd0);

        issue(1'b1, 3'b000, 32'h0000_6000, 32'h1234_56AB, 32'd1, 5'd0);
        chk_access("sb", 32'h0000_6000, 1'b1, 32'hABAB_ABAB, 4'b0010);
        respond("sb", 32'd0, 1'b0, 32'd0, 5'd0);

        issue(1'b1, 3'b010, 32'h0000_7000, 32'hCAFE_F00D, 32'd4, 5'd0);
        chk_access("sw", 32'h0000_7004, 1'b1, 32'hCAFE_F00D, 4'b1111);
        respond("sw", 32'd0, 1'b0, 32'd0, 5'd0);

        // LBU with address wrap: 0xFFFFFFFF + 2 = 0x00000001.
        issue(1'b0, 3'b100, 32'hFFFF_FFFF, 32'd0, 32'd2, 5'd9);
        chk_access("lbu", 32'h0000_0000, 1'b0, 32'd0, 4'b0000);
        respond("lbu", 32'h0000_9A00, 1'b1, 32'h0000_009A, 5'd9);

        // LH sign-extend into x0: the write-back still pulses.
        issue(1'b0, 3'b001, 32'h0000_8004, 32'd0, 32'hFFFF_FFFC, 5'd0);
        chk_access("lh", 32'h0000_8000, 1'b0, 32'd0, 4'b0000);
        respond("lh", 32'h1234_8001, 1'b1, 32'hFFFF_8001, 5'd0);

        // LW misaligned: fault at cycle 1, memory never requested.
        issue(1'b0, 3'b010, 32'h0000_3001, 32'd0, 32'd0, 5'd1);
        expect_fault("lw_mis", 2'b01);

        issue(1'b0, 3'b001, 32'h0000_3001, 32'd0, 32'd0, 5'd1);
        expect_fault("lh_mis", 2'b01);

        // Illegal funct3 wins over misalignment.
        issue(1'b1, 3'b100, 32'h0000_5001, 32'd0, 32'd0, 5'd0);
        expect_fault("st_ill", 2'b10);

        issue(1'b0, 3'b011, 32'h0000_5000, 32'd0, 32'd0, 5'd2);
        expect_fault("ld_ill", 2'b10);

        // LHU with three wait cycles; ready arrives on the last counter value.
        issue(1'b0, 3'b101, 32'h0000_4000, 32'd0, 32'd2, 5'd7);
        for (int i = 0; i < 3; i++) begin
            chk_access("lhu_wait", 32'h0000_4000, 1'b0, 32'd0, 4'b0000);
            @(negedge clk);
        end
        chk_access("lhu", 32'h0000_4000, 1'b0, 32'd0, 4'b0000);
        respond("lhu", 32'hA5A5_1234, 1'b1, 32'h0000_A5A5, 5'd7);

        // Timeout after four ACCESS cycles.
        issue(1'b0, 3'b010, 32'h0000_9000, 32'd0, 32'd0, 5'd3);
        for (int i = 0; i < 4; i++) begin
            chk_access("to_wait", 32'h0000_9000, 1'b0, 32'd0, 4'b0000);
            chk("to_fault_early", 32'(fault), 32'd0);
            @(negedge clk);
        end
        expect_fault("timeout", 2'b11);

        // Reset during ACCESS coinciding with mem_ready.
        issue(1'b0, 3'b010, 32'h0000_A000, 32'd0, 32'd0, 5'd4);
        chk_access("rst_mid", 32'h0000_A000, 1'b0, 32'd0, 4'b0000);
        rst = 1'b1;
        mem_ready = 1'b1;
        mem_rdata = 32'h1111_2222;
        @(negedge clk);
        rst = 1'b0;
        mem_ready = 1'b0;
        chk("rst_mid_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mid_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_mid_done", 32'(done), 32'd0);
        chk("rst_mid_fault", 32'(fault), 32'd0);
        chk("rst_mid_mem_addr", mem_addr, 32'd0);
        chk("rst_mid_wb_data", wb_data, 32'd0);
        chk("rst_mid_req_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        chk("rst_mid_wb_valid2", 32'(wb_valid), 32'd0);
        chk("rst_mid_done2", 32'(done), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
